lfsr_run_sequencer: RTL and testbench
=====================================

// Module: lfsr_run_sequencer
// PURPOSE
//  AXI-Lite write-master controller for the LFSR stream generator peripheral.
//  Accepts one run command (seed, taps, beat count) and programs SEED/TAPS/STOP/START.
//  Snoops the generator's AXI-Stream handshake, counts delivered beats, then halts it
//  (STOP=1, START=0). Sits between the system control logic and the generator's AXI-Lite slave port.
// PARAMETERS
//  C_AXIL_ADDR_WIDTH  4   AXI-Lite address width
//  C_AXIL_DATA_WIDTH  32  AXI-Lite data width
//  CNT_W              16  width of beat count / beat counter
// PORTS
//  aclk           in   1        clock
//  aresetn        in   1        reset; asynchronous, active-low
//  cmd_valid      in   1        run command valid
//  cmd_ready      out  1        sequencer idle, command accepted on valid&ready
//  cmd_seed       in   8        LFSR seed
//  cmd_taps       in   8        LFSR tap mask
//  cmd_count      in   CNT_W    stream beats to allow before stopping
//  abort          in   1        level; request early stop
//  m_axi_awaddr   out  ADDR_W   write address
//  m_axi_awvalid  out  1        / m_axi_awready in 1
//  m_axi_wdata    out  DATA_W   write data
//  m_axi_wvalid   out  1        / m_axi_wready in 1
//  m_axi_bresp    in   2        write response
//  m_axi_bvalid   in   1        / m_axi_bready out 1
//  mon_tvalid     in   1        snooped generator m_axis_tvalid
//  mon_tready     in   1        snooped consumer m_axis_tready
//  busy           out  1        high in every state except IDLE
//  done           out  1        one-cycle pulse on sequence completion
//  err            out  1        sticky; any non-OKAY bresp in current run
//  beats_out      out  CNT_W    beats counted in the last/current run
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (incl. cmd_ready, awaddr, wdata, beats_out).
//  cmd_ready is registered: 1 from the first clock after reset release while in IDLE.
//  Accept on cmd_valid&cmd_ready: latch seed/taps/count; clear err and beats_out.
//  Write order (addr:data): SEED 0x8:seed -> TAPS 0xC:taps -> CLRSTOP 0x4:0 -> START 0x0:1
//   -> RUN -> STOP 0x4:1 -> CLRSTART 0x0:0 -> DONE -> IDLE. Upper wdata bits are zero.
//  Each write: awvalid and wvalid are raised in the same cycle with addr/data stable.
//   Each valid drops independently after its own handshake. bready rises once both are done.
//   The write completes on bvalid&bready; the next state is entered the cycle after.
//  Only one AXI-Lite transaction is outstanding at a time. No read channel.
//  RUN: beats_out increments on mon_tvalid&mon_tready; saturates at cmd_count.
//   Exit to STOP when beats_out==cmd_count or abort=1. Beats in flight during the STOP write
//   are still counted (no saturation then) and reported in beats_out.
//  cmd_count==0: START is still written, and RUN exits in its first cycle.
//  abort outside RUN: the current write completes, then the sequence jumps to STOP.
//   abort in STOP/CLRSTART/DONE is ignored. abort in IDLE is ignored.
//  bresp!=OKAY: set err. If before STOP, jump to STOP after the response.
//   If in STOP/CLRSTART, continue normally (the halt is always attempted).
//  DONE: done=1 for exactly one cycle, busy=0 the next cycle, cmd_ready=1 the next cycle.
//  Reset mid-transaction drops all valids immediately; there is no recovery of the slave state.
// STRUCTURE
//  Package lfsr_pkg: register address localparams (START/STOP/SEED/TAPS),
//   RESP_OKAY/RESP_DECERR, and the seq_state_t enum.
//  Sub-module axil_single_write: req/addr/data in, done/resp out. Owns the AW/W/B handshake.
//   The top level owns the FSM, the beat counter and the status outputs.
// TESTING
//  1. seed=0xA5 taps=0xB8 count=4, zero-wait slave -> writes 8:A5,C:B8,4:0,0:1; 4 beats;
//     then 4:1,0:0; done pulse; beats_out=4; err=0.
//  2. awready delayed 3 cycles, wready 0 cycles (then swapped) -> awvalid/wvalid drop
//     independently; bready only after both; write order unchanged.
//  3. count=0 -> START then STOP written back-to-back; beats_out=0; done pulse.
//  4. count=10, abort after 2 beats -> STOP write follows; beats_out>=2; done; err=0.
//  5. bresp=2'b11 on TAPS write -> err=1; next writes are 4:1,0:0; done; err cleared on next cmd.
//  6. aresetn low while awvalid high -> all outputs 0 async; cmd_ready=1 one clock after release.

Source files
------------

// File: rtl/lfsr_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the LFSR run sequencer:
//   - register map of the LFSR stream generator's AXI-Lite slave
//   - AXI write response encodings
//   - sequencer state enumeration and small state-class helpers
// ---------------------------------------------------------------------------
package lfsr_pkg;

    // Generator register map (byte addresses)
    localparam logic [3:0] REG_START = 4'h0;
    localparam logic [3:0] REG_STOP  = 4'h4;
    localparam logic [3:0] REG_SEED  = 4'h8;
    localparam logic [3:0] REG_TAPS  = 4'hC;

    // AXI write response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_SEED     = 4'd1,
        S_TAPS     = 4'd2,
        S_CLRSTOP  = 4'd3,
        S_START    = 4'd4,
        S_RUN      = 4'd5,
        S_STOP     = 4'd6,
        S_CLRSTART = 4'd7,
        S_DONE     = 4'd8
    } seq_state_t;

    // States that issue exactly one AXI-Lite register write
    function automatic logic is_write_state(input seq_state_t s);
        logic r;
        case (s)
            S_SEED, S_TAPS, S_CLRSTOP, S_START, S_STOP, S_CLRSTART: r = 1'b1;
            default:                                                r = 1'b0;
        endcase
        return r;
    endfunction

    // Setup writes before the halt; an abort or error here diverts to STOP
    function automatic logic is_prestop(input seq_state_t s);
        logic r;
        case (s)
            S_SEED, S_TAPS, S_CLRSTOP, S_START: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lfsr_run_sequencer_axil.sv
// ---------------------------------------------------------------------------
// axil_single_write
// Performs one AXI-Lite write per request. AW and W are raised together with
// address/data held stable; each valid drops after its own handshake; bready
// rises once both have completed. done_o pulses on the B handshake with the
// slave's response on resp_o. Requests while a write is active are ignored.
// Ports:
//   aclk, aresetn         clock, async active-low reset
//   req_i, addr_i, data_i write request (one cycle) with address/data
//   done_o, resp_o        write completion pulse and its response
//   m_axi_aw*/w*/b*       AXI-Lite write channels
// ---------------------------------------------------------------------------
module axil_single_write #(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          req_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] data_i,
    output logic          done_o,
    output logic [1:0]    resp_o,
    output logic [AW-1:0] m_axi_awaddr,
    output logic          m_axi_awvalid,
    input  logic          m_axi_awready,
    output logic [DW-1:0] m_axi_wdata,
    output logic          m_axi_wvalid,
    input  logic          m_axi_wready,
    input  logic [1:0]    m_axi_bresp,
    input  logic          m_axi_bvalid,
    output logic          m_axi_bready
);

    logic          active_q, active_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          bready_q, bready_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          start_s;
    logic          aw_hs_s;
    logic          w_hs_s;
    logic          b_hs_s;

    assign start_s = req_i & ~active_q;
    assign aw_hs_s = awvalid_q & m_axi_awready;
    assign w_hs_s  = wvalid_q & m_axi_wready;
    assign b_hs_s  = bready_q & m_axi_bvalid;

    // Next-state logic for the single outstanding write
    always_comb begin
        active_d  = active_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        addr_d    = addr_q;
        data_d    = data_q;
        if (start_s) begin
            active_d  = 1'b1;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            addr_d    = addr_i;
            data_d    = data_i;
        end else begin
            if (aw_hs_s) awvalid_d = 1'b0;
            else         awvalid_d = awvalid_q;
            if (w_hs_s)  wvalid_d = 1'b0;
            else         wvalid_d = wvalid_q;
            if (b_hs_s) begin
                active_d = 1'b0;
                bready_d = 1'b0;
            end else if (active_q && !awvalid_d && !wvalid_d) begin
                // both address and data accepted: open the response channel
                bready_d = 1'b1;
            end else begin
                bready_d = bready_q;
            end
        end
    end

    // Write channel registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            active_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            addr_q    <= {AW{1'b0}};
            data_q    <= {DW{1'b0}};
        end else begin
            active_q  <= active_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = data_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign done_o        = b_hs_s;
    assign resp_o        = m_axi_bresp;

endmodule

// File: rtl/lfsr_run_sequencer.sv
// ---------------------------------------------------------------------------
// lfsr_run_sequencer
// AXI-Lite write master that runs the LFSR stream generator for one command:
// SEED, TAPS, clear STOP, START, count streamed beats, then STOP and clear
// START. Status outputs are registered.
// Ports:
//   aclk, aresetn            clock, async active-low reset
//   cmd_*                    run command (valid/ready, seed, taps, beat count)
//   abort                    level request to stop early
//   m_axi_aw*/w*/b*          AXI-Lite write channels to the generator
//   mon_tvalid, mon_tready   snooped generator stream handshake
//   busy, done, err          status (busy outside IDLE, done pulse, sticky err)
//   beats_out                beats counted in the last/current run
// ---------------------------------------------------------------------------
module lfsr_run_sequencer
    import lfsr_pkg::*;
#(
    parameter int C_AXIL_ADDR_WIDTH = 4,
    parameter int C_AXIL_DATA_WIDTH = 32,
    parameter int CNT_W             = 16
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [7:0]                   cmd_seed,
    input  logic [7:0]                   cmd_taps,
    input  logic [CNT_W-1:0]             cmd_count,
    input  logic                         abort,
    output logic [C_AXIL_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                         m_axi_awvalid,
    input  logic                         m_axi_awready,
    output logic [C_AXIL_DATA_WIDTH-1:0] m_axi_wdata,
    output logic                         m_axi_wvalid,
    input  logic                         m_axi_wready,
    input  logic [1:0]                   m_axi_bresp,
    input  logic                         m_axi_bvalid,
    output logic                         m_axi_bready,
    input  logic                         mon_tvalid,
    input  logic                         mon_tready,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [CNT_W-1:0]             beats_out
);

    localparam int AW = C_AXIL_ADDR_WIDTH;
    localparam int DW = C_AXIL_DATA_WIDTH;

    seq_state_t       state_q, state_d;
    logic [7:0]       seed_q, seed_d;
    logic [7:0]       taps_q, taps_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             abort_pend_q, abort_pend_d;
    logic             issued_q, issued_d;
    logic             busy_q, done_q, cmd_ready_q;

    logic             accept_s;
    logic             beat_s;
    logic             run_exit_s;
    logic             jump_s;
    logic             wr_req_s;
    logic [AW-1:0]    wr_addr_s;
    logic [DW-1:0]    wr_data_s;
    logic             wr_done_s;
    logic [1:0]       wr_resp_s;

    assign accept_s   = cmd_valid & cmd_ready_q;
    assign beat_s     = mon_tvalid & mon_tready;
    assign run_exit_s = (cnt_q == count_q) | abort;
    // a setup write that failed, or an abort seen at any point during setup,
    // sends the sequence straight to the halt writes
    assign jump_s     = abort_pend_q | abort | (wr_resp_s != RESP_OKAY);

    axil_single_write #(.AW(AW), .DW(DW)) u_wr (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .req_i         (wr_req_s),
        .addr_i        (wr_addr_s),
        .data_i        (wr_data_s),
        .done_o        (wr_done_s),
        .resp_o        (wr_resp_s),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready)
    );

    // Sequencer state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Sequencer next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) state_d = S_SEED;
                else          state_d = S_IDLE;
            end
            S_SEED: begin
                if (wr_done_s) state_d = jump_s ? S_STOP : S_TAPS;
                else           state_d = S_SEED;
            end
            S_TAPS: begin
                if (wr_done_s) state_d = jump_s ? S_STOP : S_CLRSTOP;
                else           state_d = S_TAPS;
            end
            S_CLRSTOP: begin
                if (wr_done_s) state_d = jump_s ? S_STOP : S_START;
                else           state_d = S_CLRSTOP;
            end
            S_START: begin
                if (wr_done_s) state_d = jump_s ? S_STOP : S_RUN;
                else           state_d = S_START;
            end
            S_RUN: begin
                if (run_exit_s) state_d = S_STOP;
                else            state_d = S_RUN;
            end
            S_STOP: begin
                // the halt is always completed, whatever the response
                if (wr_done_s) state_d = S_CLRSTART;
                else           state_d = S_STOP;
            end
            S_CLRSTART: begin
                if (wr_done_s) state_d = S_DONE;
                else           state_d = S_CLRSTART;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Write request decode: one request per write state, address/data by state
    always_comb begin
        wr_addr_s = {AW{1'b0}};
        wr_data_s = {DW{1'b0}};
        case (state_q)
            S_SEED: begin
                wr_addr_s = AW'(REG_SEED);
                wr_data_s = DW'(seed_q);
            end
            S_TAPS: begin
                wr_addr_s = AW'(REG_TAPS);
                wr_data_s = DW'(taps_q);
            end
            S_CLRSTOP: begin
                wr_addr_s = AW'(REG_STOP);
                wr_data_s = {DW{1'b0}};
            end
            S_START: begin
                wr_addr_s = AW'(REG_START);
                wr_data_s = DW'(1'b1);
            end
            S_STOP: begin
                wr_addr_s = AW'(REG_STOP);
                wr_data_s = DW'(1'b1);
            end
            S_CLRSTART: begin
                wr_addr_s = AW'(REG_START);
                wr_data_s = {DW{1'b0}};
            end
            default: begin
                wr_addr_s = {AW{1'b0}};
                wr_data_s = {DW{1'b0}};
            end
        endcase
        if (is_write_state(state_q) && !issued_q) wr_req_s = 1'b1;
        else                                      wr_req_s = 1'b0;
    end

    // Command latch, beat counter, error and abort tracking
    always_comb begin
        seed_d       = seed_q;
        taps_d       = taps_q;
        count_d      = count_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        abort_pend_d = abort_pend_q;
        if (accept_s) begin
            seed_d       = cmd_seed;
            taps_d       = cmd_taps;
            count_d      = cmd_count;
            cnt_d        = {CNT_W{1'b0}};
            err_d        = 1'b0;
            abort_pend_d = 1'b0;
        end else begin
            if (wr_done_s && (wr_resp_s != RESP_OKAY)) err_d = 1'b1;
            else                                       err_d = err_q;
            if (abort && is_prestop(state_q)) abort_pend_d = 1'b1;
            else                              abort_pend_d = abort_pend_q;
            // saturate while running; beats still in flight during the
            // STOP write are counted without a limit
            if (beat_s && (state_q == S_RUN) && (cnt_q != count_q))
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            else if (beat_s && (state_q == S_STOP))
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            else
                cnt_d = cnt_q;
        end
        if (wr_done_s)     issued_d = 1'b0;
        else if (wr_req_s) issued_d = 1'b1;
        else               issued_d = issued_q;
    end

    // Datapath and registered status outputs
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            seed_q       <= 8'h00;
            taps_q       <= 8'h00;
            count_q      <= {CNT_W{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            err_q        <= 1'b0;
            abort_pend_q <= 1'b0;
            issued_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cmd_ready_q  <= 1'b0;
        end else begin
            seed_q       <= seed_d;
            taps_q       <= taps_d;
            count_q      <= count_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            abort_pend_q <= abort_pend_d;
            issued_q     <= issued_d;
            busy_q       <= (state_d != S_IDLE);
            done_q       <= (state_d == S_DONE);
            cmd_ready_q  <= (state_d == S_IDLE);
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign beats_out = cnt_q;

endmodule

// File: tb/tb_lfsr_run_sequencer.sv
module tb_lfsr_run_sequencer;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [7:0]    cmd_seed = 8'h00;
    logic [7:0]    cmd_taps = 8'h00;
    logic [CW-1:0] cmd_count = 16'd0;
    logic          abort = 1'b0;
    logic [AW-1:0] m_axi_awaddr;
    logic          m_axi_awvalid;
    logic          m_axi_awready;
    logic [DW-1:0] m_axi_wdata;
    logic          m_axi_wvalid;
    logic          m_axi_wready;
    logic [1:0]    m_axi_bresp;
    logic          m_axi_bvalid;
    logic          m_axi_bready;
    logic          mon_tvalid = 1'b0;
    logic          mon_tready = 1'b0;
    logic          busy, done, err;
    logic [CW-1:0] beats_out;

    int n_cmp = 0;
    int n_bad = 0;

    // slave model configuration (written by tests only)
    int         aw_dly = 0;
    int         w_dly = 0;
    logic       err_en = 1'b0;
    logic [3:0] err_addr = 4'hC;

    // slave model state
    int          aw_cnt, w_cnt;
    logic        aw_ok, w_ok;
    logic [3:0]  aw_addr_r;
    logic [31:0] w_data_r;
    logic [3:0]  log_a [0:255];
    logic [31:0] log_d [0:255];
    int          log_n = 0;
    int          log_base = 0;

    // protocol monitor counters
    int   cnt_aw_only = 0, cnt_w_only = 0, bready_viol = 0, rise_viol = 0;
    logic prev_aw = 1'b0, prev_w = 1'b0;

    lfsr_run_sequencer #(.C_AXIL_ADDR_WIDTH(AW), .C_AXIL_DATA_WIDTH(DW), .CNT_W(CW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_seed(cmd_seed),
        .cmd_taps(cmd_taps), .cmd_count(cmd_count), .abort(abort),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .mon_tvalid(mon_tvalid), .mon_tready(mon_tready),
        .busy(busy), .done(done), .err(err), .beats_out(beats_out)
    );

    always #5 aclk = ~aclk;

    // AXI-Lite slave with programmable ready delays; logs every completed write
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axi_awready <= 1'b0; m_axi_wready <= 1'b0;
            m_axi_bvalid  <= 1'b0; m_axi_bresp  <= 2'b00;
            aw_cnt <= 0; w_cnt <= 0; aw_ok <= 1'b0; w_ok <= 1'b0;
            aw_addr_r <= 4'h0; w_data_r <= 32'h0;
        end else begin
            if (m_axi_awready && m_axi_awvalid) begin
                m_axi_awready <= 1'b0; aw_ok <= 1'b1; aw_cnt <= 0; aw_addr_r <= m_axi_awaddr;
            end else if (m_axi_awvalid && !aw_ok && !m_axi_awready) begin
                if (aw_cnt >= aw_dly) m_axi_awready <= 1'b1;
                else aw_cnt <= aw_cnt + 1;
            end
            if (m_axi_wready && m_axi_wvalid) begin
                m_axi_wready <= 1'b0; w_ok <= 1'b1; w_cnt <= 0; w_data_r <= m_axi_wdata;
            end else if (m_axi_wvalid && !w_ok && !m_axi_wready) begin
                if (w_cnt >= w_dly) m_axi_wready <= 1'b1;
                else w_cnt <= w_cnt + 1;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                m_axi_bvalid <= 1'b0; aw_ok <= 1'b0; w_ok <= 1'b0;
                log_a[8'(log_n)] <= aw_addr_r;
                log_d[8'(log_n)] <= w_data_r;
                log_n <= log_n + 1;
            end else if (aw_ok && w_ok && !m_axi_bvalid) begin
                m_axi_bvalid <= 1'b1;
                m_axi_bresp  <= (err_en && aw_addr_r == err_addr) ? 2'b11 : 2'b00;
            end
        end
    end

    // handshake-ordering monitor, sampled away from the active edge
    always @(negedge aclk) begin
        if (aresetn) begin
            if (m_axi_awvalid && !m_axi_wvalid) cnt_aw_only = cnt_aw_only + 1;
            if (m_axi_wvalid && !m_axi_awvalid) cnt_w_only = cnt_w_only + 1;
            if (m_axi_bready && (m_axi_awvalid || m_axi_wvalid)) bready_viol = bready_viol + 1;
            if ((m_axi_awvalid && !prev_aw) != (m_axi_wvalid && !prev_w)) rise_viol = rise_viol + 1;
        end
        prev_aw = m_axi_awvalid;
        prev_w  = m_axi_wvalid;
    end

    task automatic clear_log();
        log_base = log_n;
    endtask

    task automatic send_cmd(input logic [7:0] s, input logic [7:0] t, input logic [CW-1:0] c);
        cmd_seed = s; cmd_taps = t; cmd_count = c; cmd_valid = 1'b1;
        for (int i = 0; i < 100 && cmd_ready !== 1'b1; i++) @(negedge aclk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
        end
        @(negedge aclk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_log(input int n);
        for (int i = 0; i < 400 && (log_n - log_base) < n; i++) @(negedge aclk);
        n_cmp++;
        if ((log_n - log_base) < n) begin
            n_bad++; $display("FAIL wait_log: writes=%0d required >=%0d", log_n - log_base, n);
        end
    endtask

    task automatic drive_beats(input int n);
        for (int i = 0; i < n; i++) begin
            mon_tvalid = 1'b1; mon_tready = 1'b1;
            @(negedge aclk);
        end
        mon_tvalid = 1'b0; mon_tready = 1'b0;
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done === 1'b1) begin got = 1'b1; break; end
            @(negedge aclk);
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({cmd_ready, busy, done, err, m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 7'b0 ||
            beats_out !== 16'd0 || m_axi_awaddr !== 4'h0 || m_axi_wdata !== 32'h0) begin
            n_bad++; $display("FAIL reset_outputs: rdy=%b busy=%b done=%b err=%b aw=%b w=%b b=%b beats=%0d required all 0",
                              cmd_ready, busy, done, err, m_axi_awvalid, m_axi_wvalid, m_axi_bready, beats_out);
        end
        @(negedge aclk); @(negedge aclk);
        aresetn = 1'b1;
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_early: cmd_ready=%b required 0", cmd_ready); end
        @(negedge aclk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: cmd_ready=%b required 1", cmd_ready); end
    endtask

    task automatic test_basic();
        logic [3:0]  ea [6];
        logic [31:0] ed [6];
        bit got;
        int rv;
        ea = '{4'h8, 4'hC, 4'h4, 4'h0, 4'h4, 4'h0};
        ed = '{32'hA5, 32'hB8, 32'h0, 32'h1, 32'h1, 32'h0};
        clear_log(); rv = rise_viol;
        send_cmd(8'hA5, 8'hB8, 16'd4);
        n_cmp++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            n_bad++; $display("FAIL basic_busy: busy=%b rdy=%b required 1 0", busy, cmd_ready);
        end
        wait_log(4);
        drive_beats(4);
        wait_done(got);
        n_cmp++;
        if (!got || beats_out !== 16'd4 || err !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL basic_done: done=%b beats=%0d err=%b busy=%b required 1 4 0 1", got, beats_out, err, busy);
        end
        @(negedge aclk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL basic_after_done: done=%b busy=%b rdy=%b required 0 0 1", done, busy, cmd_ready);
        end
        n_cmp++;
        if (log_n - log_base !== 6) begin n_bad++; $display("FAIL basic_nwr: got %0d required 6", log_n - log_base); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (log_a[8'(log_base + i)] !== ea[i] || log_d[8'(log_base + i)] !== ed[i]) begin
                n_bad++; $display("FAIL basic_wr%0d: got %h:%h required %h:%h", i,
                                  log_a[8'(log_base + i)], log_d[8'(log_base + i)], ea[i], ed[i]);
            end
        end
        n_cmp++;
        if (rise_viol !== rv) begin n_bad++; $display("FAIL basic_valid_rise: split rises=%0d required 0", rise_viol - rv); end
    endtask

    task automatic test_delays(input int ad, input int wd);
        logic [3:0]  ea [6];
        logic [31:0] ed [6];
        bit got;
        int ao, wo, bv;
        ea = '{4'h8, 4'hC, 4'h4, 4'h0, 4'h4, 4'h0};
        ed = '{32'h3C, 32'h1D, 32'h0, 32'h1, 32'h1, 32'h0};
        aw_dly = ad; w_dly = wd;
        clear_log(); ao = cnt_aw_only; wo = cnt_w_only; bv = bready_viol;
        send_cmd(8'h3C, 8'h1D, 16'd1);
        wait_log(4);
        drive_beats(1);
        wait_done(got);
        @(negedge aclk);
        n_cmp++;
        if (!got || beats_out !== 16'd1) begin
            n_bad++; $display("FAIL delay_done: done=%b beats=%0d required 1 1", got, beats_out);
        end
        n_cmp++;
        if (bready_viol !== bv) begin n_bad++; $display("FAIL delay_bready: early cycles=%0d required 0", bready_viol - bv); end
        n_cmp++;
        if ((ad > wd && cnt_aw_only == ao) || (wd > ad && cnt_w_only == wo)) begin
            n_bad++; $display("FAIL delay_indep: aw_only=%0d w_only=%0d required >0 for slower channel",
                              cnt_aw_only - ao, cnt_w_only - wo);
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (log_a[8'(log_base + i)] !== ea[i] || log_d[8'(log_base + i)] !== ed[i]) begin
                n_bad++; $display("FAIL delay_wr%0d: got %h:%h required %h:%h", i,
                                  log_a[8'(log_base + i)], log_d[8'(log_base + i)], ea[i], ed[i]);
            end
        end
        aw_dly = 0; w_dly = 0;
    endtask

    task automatic test_zero_count();
        logic [3:0]  ea [6];
        logic [31:0] ed [6];
        bit got;
        ea = '{4'h8, 4'hC, 4'h4, 4'h0, 4'h4, 4'h0};
        ed = '{32'h01, 32'hFF, 32'h0, 32'h1, 32'h1, 32'h0};
        clear_log();
        send_cmd(8'h01, 8'hFF, 16'd0);
        wait_done(got);
        n_cmp++;
        if (!got || beats_out !== 16'd0 || err !== 1'b0) begin
            n_bad++; $display("FAIL zero_done: done=%b beats=%0d err=%b required 1 0 0", got, beats_out, err);
        end
        @(negedge aclk);
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL zero_pulse: done=%b required 0", done); end
        n_cmp++;
        if (log_n - log_base !== 6) begin n_bad++; $display("FAIL zero_nwr: got %0d required 6", log_n - log_base); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (log_a[8'(log_base + i)] !== ea[i] || log_d[8'(log_base + i)] !== ed[i]) begin
                n_bad++; $display("FAIL zero_wr%0d: got %h:%h required %h:%h", i,
                                  log_a[8'(log_base + i)], log_d[8'(log_base + i)], ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_abort_run();
        bit got;
        clear_log();
        send_cmd(8'h55, 8'h8E, 16'd10);
        wait_log(4);
        drive_beats(2);
        abort = 1'b1;
        @(negedge aclk);
        abort = 1'b0;
        wait_done(got);
        @(negedge aclk);
        n_cmp++;
        if (!got || beats_out !== 16'd2 || err !== 1'b0) begin
            n_bad++; $display("FAIL abort_run: done=%b beats=%0d err=%b required 1 2 0", got, beats_out, err);
        end
        n_cmp++;
        if (log_n - log_base !== 6 || log_a[8'(log_base + 4)] !== 4'h4 || log_d[8'(log_base + 4)] !== 32'h1) begin
            n_bad++; $display("FAIL abort_run_stop: nwr=%0d wr4=%h:%h required 6 4:1", log_n - log_base,
                              log_a[8'(log_base + 4)], log_d[8'(log_base + 4)]);
        end
    endtask

    task automatic test_abort_early();
        logic [3:0]  ea [3];
        logic [31:0] ed [3];
        bit got;
        ea = '{4'h8, 4'h4, 4'h0};
        ed = '{32'h77, 32'h1, 32'h0};
        clear_log();
        send_cmd(8'h77, 8'h12, 16'd5);
        abort = 1'b1;
        @(negedge aclk); @(negedge aclk);
        abort = 1'b0;
        wait_done(got);
        @(negedge aclk);
        n_cmp++;
        if (!got || beats_out !== 16'd0 || log_n - log_base !== 3) begin
            n_bad++; $display("FAIL abort_early: done=%b beats=%0d nwr=%0d required 1 0 3", got, beats_out, log_n - log_base);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (log_a[8'(log_base + i)] !== ea[i] || log_d[8'(log_base + i)] !== ed[i]) begin
                n_bad++; $display("FAIL abort_early_wr%0d: got %h:%h required %h:%h", i,
                                  log_a[8'(log_base + i)], log_d[8'(log_base + i)], ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_bresp_err();
        logic [3:0]  ea [4];
        logic [31:0] ed [4];
        bit got;
        ea = '{4'h8, 4'hC, 4'h4, 4'h0};
        ed = '{32'h9A, 32'h61, 32'h1, 32'h0};
        err_en = 1'b1; err_addr = 4'hC;
        clear_log();
        send_cmd(8'h9A, 8'h61, 16'd3);
        wait_done(got);
        @(negedge aclk);
        n_cmp++;
        if (!got || err !== 1'b1 || log_n - log_base !== 4) begin
            n_bad++; $display("FAIL err_run: done=%b err=%b nwr=%0d required 1 1 4", got, err, log_n - log_base);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (log_a[8'(log_base + i)] !== ea[i] || log_d[8'(log_base + i)] !== ed[i]) begin
                n_bad++; $display("FAIL err_wr%0d: got %h:%h required %h:%h", i,
                                  log_a[8'(log_base + i)], log_d[8'(log_base + i)], ea[i], ed[i]);
            end
        end
        err_en = 1'b0;
        clear_log();
        send_cmd(8'h02, 8'h03, 16'd0);
        n_cmp++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL err_clear: err=%b required 0", err); end
        wait_done(got);
        @(negedge aclk);
        n_cmp++;
        if (!got || err !== 1'b0 || log_n - log_base !== 6) begin
            n_bad++; $display("FAIL err_next_run: done=%b err=%b nwr=%0d required 1 0 6", got, err, log_n - log_base);
        end
    endtask

    task automatic test_inflight();
        bit got;
        clear_log();
        send_cmd(8'h44, 8'h21, 16'd3);
        wait_log(4);
        // two extra beats: one refused at saturation, one during the STOP write
        drive_beats(5);
        wait_done(got);
        @(negedge aclk);
        n_cmp++;
        if (!got || beats_out !== 16'd4) begin
            n_bad++; $display("FAIL inflight: done=%b beats=%0d required 1 4", got, beats_out);
        end
    endtask

    task automatic test_reset_mid();
        clear_log();
        aw_dly = 5;
        send_cmd(8'hE1, 8'h2B, 16'd2);
        for (int i = 0; i < 50 && m_axi_awvalid !== 1'b1; i++) @(negedge aclk);
        n_cmp++;
        if (m_axi_awvalid !== 1'b1) begin n_bad++; $display("FAIL rst_mid_aw: awvalid=%b required 1", m_axi_awvalid); end
        #2;
        aresetn = 1'b0;
        #1;
        n_cmp++;
        if ({cmd_ready, busy, done, err, m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 7'b0 ||
            beats_out !== 16'd0 || m_axi_awaddr !== 4'h0 || m_axi_wdata !== 32'h0) begin
            n_bad++; $display("FAIL rst_mid_outputs: rdy=%b busy=%b aw=%b w=%b b=%b addr=%h data=%h required all 0",
                              cmd_ready, busy, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_awaddr, m_axi_wdata);
        end
        aw_dly = 0;
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ready_early: cmd_ready=%b required 0", cmd_ready); end
        @(negedge aclk);
        n_cmp++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_ready: rdy=%b busy=%b required 1 0", cmd_ready, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_delays(3, 0);
        test_delays(0, 3);
        test_zero_count();
        test_abort_run();
        test_abort_early();
        test_bresp_err();
        test_inflight();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
